// File: rtl/param_bram_loader.sv
// param_bram_loader: streams TOTAL contiguous W-bit words from a shared
// read-only BRAM port into a flat register vector (element i at [i*W +: W]).
// Addresses go out one per cycle. A valid-bit shift register as deep as the
// BRAM read latency marks which cycles carry returning data.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, nothing loaded yet; waiting for start
// ISSUE | driving bram_en with base+i, one address per cycle
// DRAIN | all addresses issued; waiting for outstanding reads to land
// DONE  | data_out complete; done held until the next start or rst
module param_bram_loader #(
  parameter int IN_SIZE    = 1,
  parameter int OUT_SIZE   = 8,
  parameter int W          = 8,
  parameter int TOTAL      = IN_SIZE * OUT_SIZE,
  parameter int ADDR_WIDTH = 18,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [W-1:0]          bram_dout,
  output logic [TOTAL*W-1:0]    data_out,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         wr_ptr;
  logic [RD_LAT-1:0]     vld_sr;
  logic                  tap;

  // Oldest stage of the valid pipeline: bram_dout holds a requested word now.
  assign tap = vld_sr[RD_LAT-1];

  // Sequencer, address generator and capture pipeline; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      base_q    <= '0;
      issue_cnt <= '0;
      wr_ptr    <= '0;
      vld_sr    <= '0;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      data_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // One valid bit per issued read; it reaches the tap when the data does.
      vld_sr <= (vld_sr << 1) | RD_LAT'(bram_en);

      if (tap) begin
        data_out[wr_ptr*W +: W] <= bram_dout;
        wr_ptr                  <= wr_ptr + CW'(1);
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_ISSUE;
            base_q    <= base_addr;
            bram_addr <= base_addr;
            bram_en   <= 1'b1;
            issue_cnt <= '0;
            wr_ptr    <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (issue_cnt == LAST) begin
            state   <= S_DRAIN;
            bram_en <= 1'b0;
          end else begin
            issue_cnt <= issue_cnt + CW'(1);
            // Wraps modulo 2^ADDR_WIDTH by truncation.
            bram_addr <= base_q + ADDR_WIDTH'(issue_cnt) + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          // Read latency is at least one cycle, so the final word always
          // lands after the last issue, i.e. while draining.
          if (tap && (wr_ptr == LAST)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          bram_en <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_bram_loader.sv
// Bench for param_bram_loader: two instances (RD_LAT=2/TOTAL=8 and
// RD_LAT=3/TOTAL=4), each fed by a BRAM model returning the address low byte.
module tb_param_bram_loader;
  localparam int AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          a_start, b_start;
  logic [AW-1:0] a_base, b_base;
  logic          a_en, b_en;
  logic [AW-1:0] a_addr, b_addr;
  logic [7:0]    a_dout, b_dout;
  logic [63:0]   a_data;
  logic [31:0]   b_data;
  logic          a_busy, a_done, b_busy, b_done;

  param_bram_loader #(.IN_SIZE(1), .OUT_SIZE(8), .W(8), .ADDR_WIDTH(AW), .RD_LAT(2)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .base_addr(a_base), .bram_en(a_en),
    .bram_addr(a_addr), .bram_dout(a_dout), .data_out(a_data), .busy(a_busy), .done(a_done));

  param_bram_loader #(.IN_SIZE(1), .OUT_SIZE(4), .W(8), .ADDR_WIDTH(AW), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .base_addr(b_base), .bram_en(b_en),
    .bram_addr(b_addr), .bram_dout(b_dout), .data_out(b_data), .busy(b_busy), .done(b_done));

  // BRAM models: address sampled on the edge, data appears RD_LAT cycles later.
  logic [7:0] pa [2];
  logic [7:0] pb [3];
  always @(posedge clk) begin
    pa[0] <= a_en ? a_addr[7:0] : 8'h00;
    pa[1] <= pa[0];
    pb[0] <= b_en ? b_addr[7:0] : 8'h00;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign a_dout = pa[1];
  assign b_dout = pb[2];

  typedef struct packed { int inst; int cyc; int addr; } addr_exp_t;
  typedef struct packed { int inst; int cyc; logic [63:0] data; } done_exp_t;

  addr_exp_t aq[$];
  done_exp_t dq[$];
  int ncount = 0;
  int checks = 0;
  int errors = 0;
  int last_done[2];

  function automatic int tot(input int inst);
    return (inst == 0) ? 8 : 4;
  endfunction
  function automatic int lat(input int inst);
    return (inst == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, ncount);
    end
  endtask

  // Reference model: a load accepted at edge e reads base+i (mod 2^18)
  // during cycle e+i, and finishes TOTAL+RD_LAT cycles after e.
  function automatic void expect_load(input int inst, input int base, input int e);
    logic [63:0] d;
    int a;
    d = '0;
    for (int i = 0; i < tot(inst); i++) begin
      a = (base + i) & 32'h3FFFF;
      aq.push_back('{inst: inst, cyc: e + i, addr: a});
      d = d | (64'(a & 255) << (8 * i));
    end
    dq.push_back('{inst: inst, cyc: e + tot(inst) + lat(inst), data: d});
    last_done[inst] = e + tot(inst) + lat(inst);
  endfunction

  logic        en_v[2], busy_v[2], done_v[2];
  logic        done_prev[2];
  logic [63:0] addr_v[2], data_v[2];
  assign en_v[0]   = a_en;
  assign en_v[1]   = b_en;
  assign busy_v[0] = a_busy;
  assign busy_v[1] = b_busy;
  assign done_v[0] = a_done;
  assign done_v[1] = b_done;
  assign addr_v[0] = 64'(a_addr);
  assign addr_v[1] = 64'(b_addr);
  assign data_v[0] = a_data;
  assign data_v[1] = 64'(b_data);

  initial begin
    done_prev[0] = 1'b0;
    done_prev[1] = 1'b0;
  end

  // Monitor: on every falling edge, pop and compare whatever the DUTs present.
  always @(negedge clk) begin
    addr_exp_t ea;
    done_exp_t ed;
    ncount++;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("busy_done_excl%0d", j), 64'(busy_v[j] & done_v[j]), 64'd0);
      if (en_v[j]) begin
        if (aq.size() == 0 || aq[0].inst != j) begin
          checks++; errors++;
          $display("FAIL addr_unexpected inst=%0d actual=%h expected=none", j, addr_v[j]);
        end else begin
          ea = aq.pop_front();
          chk("addr_cycle", 64'(ncount), 64'(ea.cyc));
          chk("addr", addr_v[j], 64'(ea.addr));
        end
      end
      if (done_v[j] && !done_prev[j]) begin
        if (dq.size() == 0 || dq[0].inst != j) begin
          checks++; errors++;
          $display("FAIL done_unexpected inst=%0d actual=1 expected=0", j);
        end else begin
          ed = dq.pop_front();
          chk("done_cycle", 64'(ncount), 64'(ed.cyc));
          chk("data_out", data_v[j], ed.data);
        end
      end
      done_prev[j] = done_v[j];
    end
    while (aq.size() != 0 && aq[0].cyc < ncount) begin
      ea = aq.pop_front();
      checks++; errors++;
      $display("FAIL addr_missing actual=none expected=%h at cycle %0d", ea.addr, ea.cyc);
    end
    while (dq.size() != 0 && dq[0].cyc < ncount) begin
      ed = dq.pop_front();
      checks++; errors++;
      $display("FAIL done_missing actual=0 expected=1 at cycle %0d", ed.cyc);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One-cycle start pulse; the model decides whether the DUT may accept it.
  task automatic pulse(input int inst, input int base);
    int e;
    e = ncount + 1;
    if (inst == 0) begin a_start = 1'b1; a_base = AW'(base); end
    else begin b_start = 1'b1; b_base = AW'(base); end
    if (e > last_done[inst]) expect_load(inst, base, e);
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((aq.size() != 0 || dq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(aq.size() + dq.size()), 64'd0);
  endtask

  task automatic rand_loads(input int inst, input int n);
    int e, off;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      e = ncount + 1;
      pulse(inst, int'($urandom_range(0, 262143)));
      if ($urandom_range(0, 1) == 1) begin
        off = int'($urandom_range(1, tot(inst) + lat(inst) + 1));
        while (ncount < e + off - 1) tick();
        pulse(inst, int'($urandom_range(0, 262143)));
      end
      wait_quiet(80);
    end
  endtask

  initial begin
    int e, e1, e2;
    a_start = 1'b0; b_start = 1'b0; a_base = '0; b_base = '0;
    last_done[0] = 0; last_done[1] = 0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_bram_en", 64'(a_en), 64'd0);
    chk("rst_bram_addr", 64'(a_addr), 64'd0);
    chk("rst_data_out", a_data, 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_b_data_out", 64'(b_data), 64'd0);
    chk("rst_b_done", 64'(b_done), 64'd0);
    tick();

    // Basic load
    pulse(0, 'h24070);
    wait_quiet(40);
    chk("load1_data", a_data, 64'h7776757473727170);

    // done holds, then restart from DONE
    repeat (3) tick();
    chk("done_held", 64'(a_done), 64'd1);
    chk("data_held", a_data, 64'h7776757473727170);
    pulse(0, 'h100);
    chk("restart_done_drop", 64'(a_done), 64'd0);
    chk("restart_busy", 64'(a_busy), 64'd1);
    chk("restart_data_kept", a_data, 64'h7776757473727170);
    wait_quiet(40);
    chk("restart_data", a_data, 64'h0706050403020100);

    // Reset during the cycle issuing base+4
    tick();
    e = ncount + 1;
    pulse(0, int'($urandom_range(0, 262143)));
    while (ncount < e + 4) tick();
    rst = 1'b1;
    aq.delete();
    dq.delete();
    last_done[0] = 0;
    tick();
    chk("midrst_bram_en", 64'(a_en), 64'd0);
    chk("midrst_busy", 64'(a_busy), 64'd0);
    chk("midrst_done", 64'(a_done), 64'd0);
    chk("midrst_data_out", a_data, 64'd0);
    rst = 1'b0;
    tick();
    pulse(0, int'($urandom_range(0, 262143)));
    wait_quiet(40);

    // start during DRAIN is ignored
    e = ncount + 1;
    pulse(0, int'($urandom_range(0, 262143)));
    while (ncount < e + 8) tick();
    pulse(0, 3);
    wait_quiet(40);

    // start held high: back-to-back loads with a one-cycle DONE
    e1 = ncount + 1;
    a_start = 1'b1;
    a_base = AW'($urandom_range(0, 262143));
    expect_load(0, int'(a_base), e1);
    tick();
    a_base = AW'($urandom_range(0, 262143));
    e2 = e1 + 8 + 2 + 1;
    expect_load(0, int'(a_base), e2);
    while (ncount < e2) tick();
    chk("b2b_done_one_cycle", 64'(a_done), 64'd0);
    chk("b2b_busy", 64'(a_busy), 64'd1);
    a_start = 1'b0;
    wait_quiet(40);

    rand_loads(0, 8);

    // Longer latency and address wrap
    pulse(1, 'h3FFFE);
    wait_quiet(40);
    chk("wrap_data", 64'(b_data), 64'h0000_0000_0100_FFFE);
    rand_loads(1, 4);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/param_bram_loader.md
Name: param_bram_loader

Overview:
- Generic, parametrised loader that streams a contiguous block of W-bit words from a shared read-only BRAM port into a flat register vector.
- Serves any layer's weights or biases: base address is a runtime input, element count and BRAM read latency are parameters.
- Sits between the shared BRAM arbiter and a layer's MAC array.
- Adds synchronous reset, restart after completion, a busy flag and a latency-tracked capture pipeline.

Parameters:
- IN_SIZE, 1, input dimension of the block being loaded
- OUT_SIZE, 8, output dimension of the block being loaded
- W, 8, bits per element
- TOTAL, IN_SIZE*OUT_SIZE, number of elements loaded
- ADDR_WIDTH, 18, BRAM address width
- RD_LAT, 2, BRAM read latency in cycles, range 1..4

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin load; sampled only in IDLE or DONE
- base_addr  in  ADDR_WIDTH  address of element 0; latched on the accepted start
- bram_en  out  1  BRAM enable / read strobe
- bram_addr  out  ADDR_WIDTH  BRAM read address
- bram_dout  in  W  BRAM read data, valid RD_LAT cycles after its address
- data_out  out  TOTAL*W  element i at bits [i*W +: W]
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  high in DONE, held until the next accepted start or rst

Behaviour:
- Reset, sampled on clk when rst=1:
  - state=IDLE; bram_en=0; bram_addr=0; data_out=0; done=0; busy=0.
  - issue counter, write pointer and valid shift register all cleared.
  - rst overrides everything, including mid-load; no capture happens on the reset edge.
- States:
  - IDLE: start=1 -> ISSUE; latch base_addr; clear counters.
  - ISSUE: one address per cycle. bram_en=1, bram_addr=base+i for i=0..TOTAL-1. After the edge that issues i=TOTAL-1, go to DRAIN and drop bram_en to 0.
  - DRAIN: bram_en=0; wait for outstanding reads to return.
  - DONE: done=1. start=1 -> ISSUE with a new base_addr latch, pointers cleared. data_out keeps its old contents until each element is overwritten.
- Capture pipeline:
  - A valid bit enters an RD_LAT-deep shift register each cycle bram_en=1.
  - When the tap is set, data_out[wp*W +: W] <= bram_dout and wp increments.
  - The edge that captures wp=TOTAL-1 moves the state to DONE. This can happen from ISSUE when TOTAL <= RD_LAT is impossible, so it always happens from DRAIN.
- Timing (start accepted at edge k):
  - Address i is driven during cycle k+1+i.
  - Element i is captured at edge k+1+i+RD_LAT.
  - done rises after edge k+TOTAL+RD_LAT. Total latency is TOTAL+RD_LAT cycles.
- Address arithmetic: base+i wraps modulo 2^ADDR_WIDTH; no error flag.
- start while busy=1 is ignored: no relatch, no restart.
- start held high continuously produces back-to-back loads. DONE lasts exactly 1 cycle between them.
- Counters are sized $clog2(TOTAL+1); no overflow is possible.
- busy and done are never high together. Both are low in IDLE.

Test Plan:
- BRAM model: RD_LAT=2, dout = low byte of the address.
  - rst, then start with base_addr=147568 (0x24070), TOTAL=8.
  - Expect addresses 0x24070..0x24077 on consecutive cycles.
  - done rises exactly 10 cycles after the start edge.
  - data_out = {0x77,0x76,...,0x70}, element 0 in the LSBs.
- Restart:
  - After the first load, hold done, then start with base_addr=0x100.
  - done drops on the next cycle; busy=1.
  - Final data_out = {0x07,...,0x00}; no stale bytes remain.
- Reset mid-load:
  - Assert rst during the cycle that issues address base+4.
  - Next cycle: state IDLE, data_out=0, bram_en=0, busy=0, done=0.
  - A fresh start then completes normally.
- start while busy:
  - Pulse start with base_addr=0x3 during DRAIN.
  - No effect: addresses and data come from the original base, and done timing is unchanged.
- Latency and wrap:
  - RD_LAT=3, TOTAL=4, base_addr=0x3FFFE.
  - Addresses are 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
  - done rises 7 cycles after start.
  - data_out = {0x01,0x00,0xFF,0xFE}.
